// File: rtl/wave_pkg.sv
// Shared definitions for the waveform crossfade switch.
// Holds the default sample width, the switch FSM state encoding and a
// constant-evaluable ceil(log2) helper used to size index ports.
package wave_pkg;

  localparam int DEF_W = 11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FADE = 1'b1
  } state_t;

  // ceil(log2(v)); usable in parameter and port-width expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wave_sel_hyst.sv
// Selector decoder with hysteresis: maps a selector code to a waveform index.
// Ports: clk, rst (async active-low), sel (selector code), target (registered index).
// Latency 1 clock; target holds whenever sel sits in a guard band near a region edge.
module wave_sel_hyst
  import wave_pkg::*;
#(
  parameter int NWAVE = 4,
  parameter int SEL_W = 7,
  parameter int HYST  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SEL_W-1:0]          sel,
  output logic [clog2(NWAVE)-1:0]   target
);

  localparam int IDX_W = clog2(NWAVE);
  localparam int R     = (1 << SEL_W) / NWAVE;
  localparam int OFF_W = clog2(R);

  localparam logic [OFF_W-1:0] LO   = OFF_W'(HYST);
  localparam logic [OFF_W-1:0] HI   = OFF_W'(R - 1 - HYST);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NWAVE - 1);

  // Regions are power-of-two sized, so the quotient and remainder are
  // simply the upper and lower selector bits.
  logic [IDX_W-1:0] cand;
  logic [OFF_W-1:0] off;
  logic             accept;

  assign cand = sel[SEL_W-1 -: IDX_W];
  assign off  = sel[OFF_W-1:0];

  // The outermost regions have no neighbour beyond their outer edge, so the
  // guard band is waived there and the full end of the travel is usable.
  always_comb begin
    accept = 1'b0;
    if ((off >= LO) && (off <= HI))        accept = 1'b1;
    if ((cand == '0)   && (off < LO))      accept = 1'b1;
    if ((cand == LAST) && (off > HI))      accept = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        target <= '0;
    else if (accept) target <= cand;
  end

endmodule

// File: rtl/wave_xfade_switch.sv
// Waveform selector that crossfades linearly over L=2^XFADE_LOG2 samples on a switch.
// Ports: clk, rst (async active-low), sel, waves (packed NWAVE*W), sample_en, wave, active_idx, busy.
// Output registered, valid one clock after a sample_en edge and held between strobes.
module wave_xfade_switch
  import wave_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int NWAVE      = 4,
  parameter int SEL_W      = 7,
  parameter int XFADE_LOG2 = 2,
  parameter int HYST       = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SEL_W-1:0]          sel,
  input  logic [NWAVE*W-1:0]        waves,
  input  logic                      sample_en,
  output logic [W-1:0]              wave,
  output logic [clog2(NWAVE)-1:0]   active_idx,
  output logic                      busy
);

  localparam int IDX_W = clog2(NWAVE);
  localparam int L     = 1 << XFADE_LOG2;
  localparam int MW    = W + XFADE_LOG2 + 1;
  localparam logic [XFADE_LOG2-1:0] LAST_STEP = '1;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      cur_q, cur_d;
  logic [IDX_W-1:0]      nxt_q, nxt_d;
  logic [XFADE_LOG2-1:0] step_q, step_d;
  logic [W-1:0]          wave_q, wave_d;
  logic [IDX_W-1:0]      target;

  logic [W-1:0]  a_smp, b_smp, mixed;
  logic [MW-1:0] wa, wb, mix;

  wave_sel_hyst #(
    .NWAVE (NWAVE),
    .SEL_W (SEL_W),
    .HYST  (HYST)
  ) u_sel (
    .clk    (clk),
    .rst    (rst),
    .sel    (sel),
    .target (target)
  );

  // Linear mix: weights (L-step) and step always sum to L, so the shifted
  // sum is a convex blend and always fits back into W bits.
  always_comb begin
    a_smp = waves[int'(cur_q)*W +: W];
    b_smp = waves[int'(nxt_q)*W +: W];
    wa    = MW'(L) - MW'(step_q);
    wb    = MW'(step_q);
    mix   = MW'(a_smp) * wa + MW'(b_smp) * wb;
    mixed = W'(mix >> XFADE_LOG2);
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    step_d  = step_q;
    wave_d  = wave_q;
    case (state_q)
      ST_IDLE: begin
        if (sample_en) begin
          wave_d = a_smp;
          if (target != cur_q) begin
            nxt_d   = target;
            step_d  = '0;
            state_d = ST_FADE;
          end
        end
      end
      ST_FADE: begin
        // Target is deliberately not looked at here; a change made during
        // the fade is picked up on the first IDLE sample afterwards.
        if (sample_en) begin
          wave_d = mixed;
          step_d = step_q + 1'b1;
          if (step_q == LAST_STEP) begin
            cur_d   = nxt_q;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      nxt_q   <= '0;
      step_q  <= '0;
      wave_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      step_q  <= step_d;
      wave_q  <= wave_d;
    end
  end

  assign wave       = wave_q;
  assign busy       = (state_q == ST_FADE);
  assign active_idx = cur_q;

endmodule

// File: tb/tb_wave_xfade_switch.sv
// Directed bench for wave_xfade_switch with a queue of expected per-strobe outputs.
// Ports driven: clk, rst, sel, waves, sample_en; observed: wave, active_idx, busy.
// Strobes every four clocks; outputs sampled on the falling edge after each strobe.
module tb_wave_xfade_switch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  sel = 7'd10;
  logic [43:0] waves;
  logic        sample_en = 1'b0;
  logic [10:0] wave;
  logic [1:0]  active_idx;
  logic        busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [10:0] w;
    logic        b;
    logic [1:0]  i;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  wave_xfade_switch #(
    .W(11), .NWAVE(4), .SEL_W(7), .XFADE_LOG2(2), .HYST(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .waves      (waves),
    .sample_en  (sample_en),
    .wave       (wave),
    .active_idx (active_idx),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Push the expectation, pulse sample_en for one clock, then pop and
  // compare on the falling edge, followed by three quiet clocks.
  task automatic strobe(input string tag, input int ew, input bit eb, input int ei);
    exp_t e;
    e.w = 11'(ew);
    e.b = eb;
    e.i = 2'(ei);
    sb.push_back(e);
    @(negedge clk);
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".wave"}, 32'(wave), 32'(e.w));
      chk({tag, ".busy"}, 32'(busy), 32'(e.b));
      chk({tag, ".idx"},  32'(active_idx), 32'(e.i));
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [10:0] w_hold;
    logic        b_hold;
    waves = {11'd1500, 11'd900, 11'd500, 11'd100};

    // Reset state
    #12;
    chk("rst.wave", 32'(wave), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.idx",  32'(active_idx), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // First strobe after reset, then hysteresis hold at sel=33
    strobe("first", 100, 0, 0);
    sel = 7'd33;
    strobe("hyst33a", 100, 0, 0);
    strobe("hyst33b", 100, 0, 0);

    // sel=34 crosses the guard band: fade 0->1
    sel = 7'd34;
    strobe("f01.s", 100, 1, 0);
    strobe("f01.0", 100, 1, 0);
    strobe("f01.1", 200, 1, 0);
    strobe("f01.2", 300, 1, 0);
    strobe("f01.3", 400, 0, 1);
    strobe("f01.e", 500, 0, 1);

    // No strobe for 50 clocks while sel wanders
    w_hold = wave;
    b_hold = busy;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      sel = 7'($urandom_range(0, 127));
    end
    chk("nostrb.wave", 32'(wave), 32'd500);
    chk("nostrb.busy", 32'(busy), 32'd0);
    chk("nostrb.hold", 32'({wave, busy}), 32'({w_hold, b_hold}));
    sel = 7'd40;
    strobe("hold1", 500, 0, 1);

    // Back to 0 via lower outer edge, then edge jump to 3
    sel = 7'd0;
    strobe("f10.s", 500, 1, 1);
    strobe("f10.0", 500, 1, 1);
    strobe("f10.1", 400, 1, 1);
    strobe("f10.2", 300, 1, 1);
    strobe("f10.3", 200, 0, 0);
    strobe("f10.e", 100, 0, 0);
    sel = 7'd127;
    strobe("f03.s", 100, 1, 0);
    strobe("f03.0", 100, 1, 0);
    strobe("f03.1", 450, 1, 0);
    strobe("f03.2", 800, 1, 0);
    strobe("f03.3", 1150, 0, 3);
    strobe("f03.e", 1500, 0, 3);

    // Return to 0, then fade 0->1 with a change to region 3 mid-fade
    sel = 7'd10;
    strobe("f30.s", 1500, 1, 3);
    strobe("f30.0", 1500, 1, 3);
    strobe("f30.1", 1150, 1, 3);
    strobe("f30.2", 800, 1, 3);
    strobe("f30.3", 450, 0, 0);
    strobe("f30.e", 100, 0, 0);
    sel = 7'd40;
    strobe("mid.s", 100, 1, 0);
    strobe("mid.0", 100, 1, 0);
    sel = 7'd100;
    strobe("mid.1", 200, 1, 0);
    strobe("mid.2", 300, 1, 0);
    strobe("mid.3", 400, 0, 1);
    strobe("f13.s", 500, 1, 1);
    strobe("f13.0", 500, 1, 1);
    strobe("f13.1", 750, 1, 1);
    strobe("f13.2", 1000, 1, 1);
    strobe("f13.3", 1250, 0, 3);
    strobe("f13.e", 1500, 0, 3);

    // Asynchronous reset in the middle of a fade
    sel = 7'd10;
    strobe("rf.s", 1500, 1, 3);
    strobe("rf.0", 1500, 1, 3);
    strobe("rf.1", 1150, 1, 3);
    #2;
    rst = 1'b0;
    #1;
    chk("arst.wave", 32'(wave), 32'd0);
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.idx",  32'(active_idx), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    strobe("post", 100, 0, 0);

    chk("sb.empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
